// File: rtl/fp16_pkg.sv
// Shared types and constants for the half-precision adder datapath.
// Imported by the exception unit and the sequential adder core.
package fp16_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic [4:0]  EXP_MAX     = 5'h1F;
    localparam logic [15:0] POS_INF     = 16'h7C00;
    localparam int          QNAN_FRAC_W = 10;
    localparam int          SIG_W       = 11;
    localparam int          EXT_W       = 14;

endpackage

// File: rtl/exception16_sum.sv
// Special-case screen for binary16 addition: NaN, Inf and zero operands.
// Flags when the sum is fully determined without arithmetic.
module exception16_sum
    import fp16_pkg::*;
(
    input  logic             sign_a,
    input  logic [4:0]       exp_a,
    input  logic [SIG_W-1:0] mant_a,
    input  logic             sign_b,
    input  logic [4:0]       exp_b,
    input  logic [SIG_W-1:0] mant_b,
    output logic [15:0]      q,
    output logic             flag
);

    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign nan_a  = (exp_a == EXP_MAX) && (mant_a[QNAN_FRAC_W-1:0] != '0);
    assign nan_b  = (exp_b == EXP_MAX) && (mant_b[QNAN_FRAC_W-1:0] != '0);
    assign inf_a  = (exp_a == EXP_MAX) && (mant_a[QNAN_FRAC_W-1:0] == '0);
    assign inf_b  = (exp_b == EXP_MAX) && (mant_b[QNAN_FRAC_W-1:0] == '0);
    assign zero_a = (exp_a == 5'd0) && (mant_a == '0);
    assign zero_b = (exp_b == 5'd0) && (mant_b == '0);

    // NaNs are propagated quieted; Inf - Inf yields the default quiet NaN
    always_comb begin
        flag = 1'b0;
        q    = '0;
        if (nan_a) begin
            flag = 1'b1;
            q    = {sign_a, EXP_MAX, 1'b1, mant_a[QNAN_FRAC_W-2:0]};
        end else if (nan_b) begin
            flag = 1'b1;
            q    = {sign_b, EXP_MAX, 1'b1, mant_b[QNAN_FRAC_W-2:0]};
        end else if (inf_a && inf_b && (sign_a != sign_b)) begin
            flag = 1'b1;
            q    = {1'b0, EXP_MAX, 1'b1, {(QNAN_FRAC_W-1){1'b0}}};
        end else if (inf_a) begin
            flag = 1'b1;
            q    = {sign_a, EXP_MAX, {QNAN_FRAC_W{1'b0}}};
        end else if (inf_b) begin
            flag = 1'b1;
            q    = {sign_b, EXP_MAX, {QNAN_FRAC_W{1'b0}}};
        end else if (zero_a && zero_b) begin
            flag = 1'b1;
            q    = {sign_a & sign_b, 15'd0};
        end else if (zero_a) begin
            flag = 1'b1;
            q    = {sign_b, exp_b, mant_b[QNAN_FRAC_W-1:0]};
        end else if (zero_b) begin
            flag = 1'b1;
            q    = {sign_a, exp_a, mant_a[QNAN_FRAC_W-1:0]};
        end
    end

endmodule

// File: rtl/fp16_add_seq.sv
// Multi-cycle binary16 adder: screen, align, add, iterative normalize,
// round-to-nearest-even, with valid/ready handshakes on both sides.
module fp16_add_seq
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic        exc_out,
    output logic        ovf
);

    state_t           state;
    logic [15:0]      ra, rb;
    logic             xs, ys;
    logic [5:0]       ex;
    logic [EXT_W:0]   sig;
    logic [EXT_W-1:0] ysig;

    logic [15:0] exc_q;
    logic        exc_flag;

    assign in_ready = (state == S_IDLE);

    exception16_sum u_exc (
        .sign_a (ra[15]),
        .exp_a  (ra[14:10]),
        .mant_a ({1'b0, ra[9:0]}),
        .sign_b (rb[15]),
        .exp_b  (rb[14:10]),
        .mant_b ({1'b0, rb[9:0]}),
        .q      (exc_q),
        .flag   (exc_flag)
    );

    // Align: larger magnitude becomes X, Y is shifted right with sticky
    logic [15:0]      x, y;
    logic [4:0]       xe, ye, d;
    logic [EXT_W-1:0] x_ext, y_ext, y_tmp, y_mask, y_sh;

    always_comb begin
        if (ra[14:0] >= rb[14:0]) begin
            x = ra;
            y = rb;
        end else begin
            x = rb;
            y = ra;
        end
        xe     = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ye     = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        x_ext  = {x[14:10] != 5'd0, x[9:0], 3'b000};
        y_ext  = {y[14:10] != 5'd0, y[9:0], 3'b000};
        d      = xe - ye;
        y_tmp  = y_ext >> d;
        y_mask = (14'd1 << d) - 14'd1;
        if (d >= 5'd14)
            y_sh = {13'd0, |y_ext};
        else
            y_sh = {y_tmp[13:1], y_tmp[0] | (|(y_ext & y_mask))};
    end

    // Round to nearest even on guard / round|sticky / lsb
    logic [SIG_W-1:0] m, mant;
    logic [SIG_W:0]   mr;
    logic             inc, rnd_ovf;
    logic [5:0]       e_rnd;
    logic [15:0]      rnd_q;

    always_comb begin
        m     = sig[13:3];
        inc   = sig[2] & ((|sig[1:0]) | m[0]);
        mr    = {1'b0, m} + {{SIG_W{1'b0}}, inc};
        mant  = mr[SIG_W] ? mr[SIG_W:1] : mr[SIG_W-1:0];
        e_rnd = mr[SIG_W] ? ex + 6'd1 : ex;
        rnd_ovf = mant[10] && (e_rnd >= 6'd31);
        if (rnd_ovf)
            rnd_q = POS_INF | {xs, 15'd0};
        else if (mant[10])
            rnd_q = {xs, e_rnd[4:0], mant[9:0]};
        else
            rnd_q = {xs, 5'd0, mant[9:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            q         <= '0;
            exc_out   <= 1'b0;
            ovf       <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            xs        <= 1'b0;
            ys        <= 1'b0;
            ex        <= '0;
            sig       <= '0;
            ysig      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        ra    <= a;
                        rb    <= b;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (exc_flag) begin
                        q         <= exc_q;
                        exc_out   <= 1'b1;
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    xs    <= x[15];
                    ys    <= y[15];
                    ex    <= {1'b0, xe};
                    sig   <= {1'b0, x_ext};
                    ysig  <= y_sh;
                    state <= S_ADD;
                end
                S_ADD: begin
                    if (xs == ys) begin
                        sig <= sig + {1'b0, ysig};
                    end else begin
                        sig <= sig - {1'b0, ysig};
                        if (sig[13:0] == ysig)
                            xs <= 1'b0;
                    end
                    state <= S_NORM;
                end
                S_NORM: begin
                    if (sig[14]) begin
                        sig   <= {1'b0, sig[14:2], sig[1] | sig[0]};
                        ex    <= ex + 6'd1;
                        state <= S_ROUND;
                    end else if (!sig[13] && ex > 6'd1 && sig != '0) begin
                        sig <= {sig[13:0], 1'b0};
                        ex  <= ex - 6'd1;
                        // leave on the last shift so NORM lasts exactly n cycles
                        if (sig[12] || ex == 6'd2)
                            state <= S_ROUND;
                    end else begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    q         <= rnd_q;
                    ovf       <= rnd_ovf;
                    exc_out   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
